muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file read ports: rs/rt operand data feeds `a`/`b`, and `hi`/`lo` return to the datapath for MFHI/MFLO writeback. It executes MULT, MULTU, DIV and DIVU with a fixed 34-cycle latency and accepts MTHI/MTLO writes when idle.

---
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand, HI/LO write and result bundle between the datapath and muldiv_unit.
// fsm_state mirrors the unit's FSM encoding for observation.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  hi_wr_en;
  logic                  lo_wr_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [1:0]            fsm_state;

  modport master (
    output start, op, a, b, hi_wr_en, lo_wr_en, w_data,
    input  busy, done, div_zero, hi, lo, fsm_state
  );

  modport slave (
    input  start, op, a, b, hi_wr_en, lo_wr_en, w_data,
    output busy, done, div_zero, hi, lo, fsm_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one bit per cycle,
// fixed latency of DATA_WIDTH + 2 edges from start acceptance to done.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  // Handshake: start is taken at a rising edge only while busy=0 (otherwise
  // ignored, operands not sampled); done pulses for one cycle once HI/LO hold
  // the result, and a new start may be accepted in that same done cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [5:0]       cnt;
  logic [W-1:0]     opnd;
  logic [2*W-1:0]   acc;
  logic             neg_q, neg_r;
  logic [W-1:0]     hi_q, lo_q;
  logic             done_q, div_zero_q;

  logic             sign_a, sign_b;
  logic [W-1:0]     mag_a, mag_b;
  logic             last_iter;
  logic [W:0]       add_sum;
  logic [W:0]       rem_sh, rem_diff;
  logic [2*W-1:0]   acc_next;
  logic [2*W-1:0]   prod;
  logic             div_by_zero;
  logic [W-1:0]     res_hi, res_lo;

  assign sign_a    = bus.op[0] & bus.a[W-1];
  assign sign_b    = bus.op[0] & bus.b[W-1];
  assign mag_a     = sign_a ? -bus.a : bus.a;
  assign mag_b     = sign_b ? -bus.b : bus.b;
  assign last_iter = (cnt == 6'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_CALC;
      S_CALC:  if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One iteration: multiply adds the multiplicand into the upper half and
  // shifts right (carry included); divide shifts left and trial-subtracts.
  always_comb begin
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, opnd};
    acc_next = {add_sum, acc[W-1:1]};
    if (op_q[1]) begin
      if (!rem_diff[W]) acc_next = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
      else              acc_next = {rem_sh[W-1:0],   acc[W-2:0], 1'b0};
    end
  end

  // A zero divisor leaves quotient all-ones and remainder |a|; re-signing the
  // remainder with sign(a) recovers a exactly, so only LO needs forcing.
  always_comb begin
    prod        = neg_q ? -acc : acc;
    div_by_zero = op_q[1] && (opnd == '0);
    res_hi      = prod[2*W-1:W];
    res_lo      = prod[W-1:0];
    if (op_q[1]) begin
      res_hi = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (div_by_zero) res_lo = '1;
      else             res_lo = neg_q ? -acc[W-1:0] : acc[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 2'b00;
      cnt        <= 6'd0;
      opnd       <= '0;
      acc        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.hi_wr_en) hi_q <= bus.w_data;
          if (bus.lo_wr_en) lo_q <= bus.w_data;
          if (bus.start) begin
            op_q  <= bus.op;
            cnt   <= 6'd0;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a & bus.op[1];
            if (bus.op[1]) begin
              acc  <= {{W{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{W{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
        end
        S_FIX: begin
          hi_q       <= res_hi;
          lo_q       <= res_lo;
          done_q     <= 1'b1;
          div_zero_q <= div_by_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: products, quotients, divide-by-zero,
// busy-time interference, MTLO, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start at the current negedge; return at the negedge after edge 0
  // with operands scrambled so the unit must not depend on them.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // From the negedge after edge 0, count edges until done; lat = 0 on timeout.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/div_zero=%b%b%b expected 000", bus.busy, bus.done, bus.div_zero);
    end
    tests_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
    end
    tests_run++;
    if (bus.fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", bus.fsm_state);
    end
  endtask

  task automatic test_mult();
    logic [1:0]   ops   [4];
    logic [W-1:0] av    [4];
    logic [W-1:0] bv    [4];
    logic [W-1:0] exp_h [4];
    logic [W-1:0] exp_l [4];
    int lat, busy_n;
    ops   = '{2'b00, 2'b01, 2'b01, 2'b01};
    av    = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    bv    = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'hFFFFFFFF};
    exp_h = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
    exp_l = '{32'h00000001, 32'hFFFFFFF1, 32'h00000000, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], av[i], bv[i]);
      tests_run++;
      if (bus.fsm_state !== 2'd1) begin
        tests_failed++;
        $display("FAIL mult_calc_state[%0d]: got %0d expected 1", i, bus.fsm_state);
      end
      wait_done(lat, busy_n);
      tests_run++;
      if (lat != 33 || busy_n != 33) begin
        tests_failed++;
        $display("FAIL mult_timing[%0d]: done after edge %0d busy cycles %0d expected 33/33", i, lat, busy_n);
      end
      tests_run++;
      if (bus.hi !== exp_h[i] || bus.lo !== exp_l[i] || bus.div_zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL mult_result[%0d]: hi=%h lo=%h dz=%b expected %h %h 0", i, bus.hi, bus.lo, bus.div_zero, exp_h[i], exp_l[i]);
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.hi !== exp_h[i] || bus.lo !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL mult_done_pulse[%0d]: done=%b hi=%h lo=%h expected 0 %h %h", i, bus.done, bus.hi, bus.lo, exp_h[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]   ops   [5];
    logic [W-1:0] av    [5];
    logic [W-1:0] bv    [5];
    logic [W-1:0] exp_h [5];
    logic [W-1:0] exp_l [5];
    int lat, busy_n;
    ops   = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10};
    av    = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFFF};
    bv    = '{32'h00000002, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2};
    exp_l = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD, 32'h7FFFFFFF};
    exp_h = '{32'hFFFFFFFF, 32'd2, 32'h00000000, 32'h00000001, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      launch(ops[i], av[i], bv[i]);
      wait_done(lat, busy_n);
      tests_run++;
      if (lat != 33) begin
        tests_failed++;
        $display("FAIL div_latency[%0d]: done after edge %0d expected 33", i, lat);
      end
      tests_run++;
      if (bus.hi !== exp_h[i] || bus.lo !== exp_l[i] || bus.div_zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL div_result[%0d]: hi=%h lo=%h dz=%b expected %h %h 0", i, bus.hi, bus.lo, bus.div_zero, exp_h[i], exp_l[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]   ops   [2];
    logic [W-1:0] av    [2];
    logic [W-1:0] exp_h [2];
    int lat, busy_n;
    ops   = '{2'b10, 2'b11};
    av    = '{32'd100, 32'hFFFFFFFB};
    exp_h = '{32'h00000064, 32'hFFFFFFFB};
    for (int i = 0; i < 2; i++) begin
      launch(ops[i], av[i], 32'h0);
      wait_done(lat, busy_n);
      tests_run++;
      if (lat != 33 || bus.div_zero !== 1'b1) begin
        tests_failed++;
        $display("FAIL divzero_flag[%0d]: edge %0d div_zero=%b expected 33 1", i, lat, bus.div_zero);
      end
      tests_run++;
      if (bus.hi !== exp_h[i] || bus.lo !== 32'hFFFFFFFF) begin
        tests_failed++;
        $display("FAIL divzero_result[%0d]: hi=%h lo=%h expected %h ffffffff", i, bus.hi, bus.lo, exp_h[i]);
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL divzero_pulse[%0d]: div_zero=%b done=%b expected 0 0", i, bus.div_zero, bus.done);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int e, lat, busy_n;
    // MTHI on the same edge as an accepted start takes effect.
    bus.hi_wr_en = 1'b1;
    bus.w_data   = 32'h00001111;
    launch(2'b00, 32'd6, 32'd7);
    bus.hi_wr_en = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h00001111 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_edge_mthi: hi=%h busy=%b expected 00001111 1", bus.hi, bus.busy);
    end
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 2'b10;
    bus.a        = 32'd9;
    bus.b        = 32'd3;
    bus.hi_wr_en = 1'b1;
    bus.w_data   = 32'h0000DEAD;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.hi_wr_en = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h00001111) begin
      tests_failed++;
      $display("FAIL busy_mthi_ignored: hi=%h expected 00001111", bus.hi);
    end
    e = 10;
    while (e < 80 && !bus.done) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    tests_run++;
    if (e != 33 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: edge %0d hi=%h lo=%h expected 33 0 2a", e, bus.hi, bus.lo);
    end
    // Back-to-back: start in the done cycle, accepted at edge 34.
    launch(2'b00, 32'd2, 32'd5);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.lo !== 32'd42) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b lo=%h expected 1 2a", bus.busy, bus.lo);
    end
    wait_done(lat, busy_n);
    tests_run++;
    if (lat != 33 || bus.lo !== 32'd10 || bus.hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_result: edge %0d hi=%h lo=%h expected 33 0 a", lat, bus.hi, bus.lo);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_mtlo();
    bus.hi_wr_en = 1'b1;
    bus.w_data   = 32'h0000ABCD;
    @(posedge clk);
    @(negedge clk);
    bus.hi_wr_en = 1'b0;
    bus.lo_wr_en = 1'b1;
    bus.w_data   = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.lo_wr_en = 1'b0;
    tests_run++;
    if (bus.lo !== 32'h12345678 || bus.hi !== 32'h0000ABCD || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo_idle: hi=%h lo=%h busy=%b expected 0000abcd 12345678 0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n;
    launch(2'b00, 32'd7, 32'd9);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h state=%0d expected 0 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo, bus.fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_result: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    launch(2'b00, 32'd2, 32'd3);
    wait_done(lat, busy_n);
    tests_run++;
    if (lat != 33 || busy_n != 33 || bus.lo !== 32'd6 || bus.hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_op: edge %0d busy %0d hi=%h lo=%h expected 33 33 0 6", lat, busy_n, bus.hi, bus.lo);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    bus.hi_wr_en = 1'b0;
    bus.lo_wr_en = 1'b0;
    bus.w_data   = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_mtlo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
